// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: ALU commands, shift types,
// FSM states and NZCV bit positions.
package exe_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_fwd_mc_val2_shifter.sv
// Second-operand generator: memory offset, rotated immediate, or shifted Rm.
module val2_shifter
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] val_rm,
   input  logic [11:0]       shift_operand,
   input  logic              imm,
   input  logic              mem,
   output logic [DATA_W-1:0] val2
);

   // Rotate right with the amount reduced modulo the datapath width.
   function automatic logic [DATA_W-1:0] ror_f(input logic [DATA_W-1:0] x,
                                               input logic [31:0] amt);
      logic [31:0] a;
      a = amt % 32'(DATA_W);
      return (x >> a) | (x << (32'(DATA_W) - a));
   endfunction

   logic [DATA_W-1:0] imm8_s;
   logic [31:0]       rot_amt_s;
   logic [31:0]       sh_amt_s;

   // Select the Val2 source; address offsets take priority over immediates.
   always_comb begin
      imm8_s    = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
      rot_amt_s = 32'({shift_operand[11:8], 1'b0});
      sh_amt_s  = 32'(shift_operand[11:7]) % 32'(DATA_W);
      val2      = '0;
      if (mem) begin
         val2 = {{(DATA_W-12){1'b0}}, shift_operand};
      end else if (imm) begin
         val2 = ror_f(imm8_s, rot_amt_s);
      end else begin
         case (shift_operand[6:5])
            SHIFT_LSL: val2 = val_rm << sh_amt_s;
            SHIFT_LSR: val2 = val_rm >> sh_amt_s;
            SHIFT_ASR: val2 = DATA_W'($signed(val_rm) >>> sh_amt_s);
            SHIFT_ROR: val2 = ror_f(val_rm, sh_amt_s);
            default:   val2 = val_rm;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage_fwd_mc.sv
// Execute stage with operand forwarding, ALU, branch adder, multi-cycle
// multiply, NZCV register and a valid/ready EXE/MEM output register.
module exe_stage_fwd_mc
   import exe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int FWD_SRCS = 2,
   parameter int MUL_LAT  = 3,
   parameter int DEST_W   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [3:0]                   exe_cmd,
   input  logic                         mem_r_en,
   input  logic                         mem_w_en,
   input  logic                         wb_en,
   input  logic                         s_bit,
   input  logic [DEST_W-1:0]            dest,
   input  logic [DATA_W-1:0]            pc,
   input  logic [DATA_W-1:0]            val_rn,
   input  logic [DATA_W-1:0]            val_rm,
   input  logic                         imm,
   input  logic [11:0]                  shift_operand,
   input  logic [23:0]                  signed_imm_24,
   input  logic [$clog2(FWD_SRCS+1)-1:0] sel_src1,
   input  logic [$clog2(FWD_SRCS+1)-1:0] sel_src2,
   input  logic [FWD_SRCS*DATA_W-1:0]   fwd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_alu_res,
   output logic [DATA_W-1:0]            out_val_rm,
   output logic [DATA_W-1:0]            out_branch_addr,
   output logic [DEST_W-1:0]            out_dest,
   output logic                         out_wb_en,
   output logic                         out_mem_r,
   output logic                         out_mem_w,
   output logic [3:0]                   status
);

   localparam int SEL_W = $clog2(FWD_SRCS+1);
   localparam int CNT_W = $clog2(MUL_LAT+1);

   logic [DATA_W-1:0] op1_s, op2_s, val2_s, alu_res_s, branch_s, mul_res_s;
   logic [DATA_W:0]   sum_s;
   logic [3:0]        flags_s, mul_flags_s;
   logic              nz_s, mem_s, is_mul_s, accept_s, load_alu_s, load_mul_s;
   state_t            state_r, state_nx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
   logic [DATA_W-1:0] mul_a_r, mul_b_r, mul_rm_r, mul_br_r;
   logic [DEST_W-1:0] mul_dest_r;
   logic              mul_wb_r, mul_mr_r, mul_mw_r, mul_s_r;

   assign mem_s      = mem_r_en | mem_w_en;
   assign is_mul_s   = (exe_cmd == CMD_MUL);
   assign in_ready   = (state_r == ST_IDLE) & ~flush & (~out_valid | out_ready);
   assign accept_s   = in_valid & in_ready;
   assign load_alu_s = accept_s & ~is_mul_s;
   assign branch_s   = pc + DATA_W'($signed({signed_imm_24, 2'b00}));

   // Forwarding muxes: select k picks slot k-1, zero or out-of-range keeps the register value.
   always_comb begin
      op1_s = val_rn;
      op2_s = val_rm;
      for (int k = 1; k <= FWD_SRCS; k++) begin
         op1_s = (sel_src1 == SEL_W'(k)) ? fwd_data[(k-1)*DATA_W +: DATA_W] : op1_s;
         op2_s = (sel_src2 == SEL_W'(k)) ? fwd_data[(k-1)*DATA_W +: DATA_W] : op2_s;
      end
   end

   val2_shifter #(.DATA_W(DATA_W)) u_val2 (
      .val_rm        (op2_s),
      .shift_operand (shift_operand),
      .imm           (imm),
      .mem           (mem_s),
      .val2          (val2_s)
   );

   // Single-cycle ALU with NZCV generation; unknown commands yield 0 and keep flags.
   always_comb begin
      alu_res_s = '0;
      sum_s     = '0;
      flags_s   = status;
      nz_s      = 1'b0;
      case (exe_cmd)
         CMD_MOV: begin alu_res_s = val2_s;          nz_s = 1'b1; end
         CMD_MVN: begin alu_res_s = ~val2_s;         nz_s = 1'b1; end
         CMD_AND: begin alu_res_s = op1_s & val2_s;  nz_s = 1'b1; end
         CMD_ORR: begin alu_res_s = op1_s | val2_s;  nz_s = 1'b1; end
         CMD_EOR: begin alu_res_s = op1_s ^ val2_s;  nz_s = 1'b1; end
         CMD_ADD, CMD_ADC: begin
            sum_s = {1'b0, op1_s} + {1'b0, val2_s}
                  + {{DATA_W{1'b0}}, (exe_cmd == CMD_ADC) & status[FLAG_C]};
            alu_res_s       = sum_s[DATA_W-1:0];
            flags_s[FLAG_C] = sum_s[DATA_W];
            flags_s[FLAG_V] = (op1_s[DATA_W-1] == val2_s[DATA_W-1]) &
                              (sum_s[DATA_W-1] != op1_s[DATA_W-1]);
            nz_s            = 1'b1;
         end
         CMD_SUB, CMD_SBC: begin
            // A - B - borrow computed as A + ~B + carry, so carry-out is NOT borrow.
            sum_s = {1'b0, op1_s} + {1'b0, ~val2_s}
                  + {{DATA_W{1'b0}}, (exe_cmd == CMD_SUB) | status[FLAG_C]};
            alu_res_s       = sum_s[DATA_W-1:0];
            flags_s[FLAG_C] = sum_s[DATA_W];
            flags_s[FLAG_V] = (op1_s[DATA_W-1] != val2_s[DATA_W-1]) &
                              (sum_s[DATA_W-1] != op1_s[DATA_W-1]);
            nz_s            = 1'b1;
         end
         default: alu_res_s = '0;
      endcase
      if (nz_s) begin
         flags_s[FLAG_N] = alu_res_s[DATA_W-1];
         flags_s[FLAG_Z] = (alu_res_s == '0);
      end else begin
         flags_s[FLAG_N] = status[FLAG_N];
         flags_s[FLAG_Z] = status[FLAG_Z];
      end
   end

   // Multiply result from captured operands; only N and Z are affected.
   always_comb begin
      mul_res_s           = mul_a_r * mul_b_r;
      mul_flags_s         = status;
      mul_flags_s[FLAG_N] = mul_res_s[DATA_W-1];
      mul_flags_s[FLAG_Z] = (mul_res_s == '0);
   end

   // FSM next state: count down the multiply, hold at 1 while output is occupied.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      load_mul_s = 1'b0;
      if (flush) begin
         state_nx_s = ST_IDLE;
         cnt_nx_s   = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s & is_mul_s) begin
                  state_nx_s = ST_BUSY;
                  cnt_nx_s   = CNT_W'(MUL_LAT-1);
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_r == CNT_W'(1)) begin
                  if (~out_valid | out_ready) begin
                     load_mul_s = 1'b1;
                     state_nx_s = ST_IDLE;
                     cnt_nx_s   = '0;
                  end else begin
                     cnt_nx_s   = cnt_r;
                  end
               end else begin
                  cnt_nx_s = cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = '0;
            end
         endcase
      end
   end

   // FSM state and multiply counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Capture multiply operands and side-band fields at accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_a_r <= '0; mul_b_r <= '0; mul_rm_r <= '0; mul_br_r <= '0;
         mul_dest_r <= '0; mul_wb_r <= 1'b0; mul_mr_r <= 1'b0;
         mul_mw_r <= 1'b0; mul_s_r <= 1'b0;
      end else if (accept_s & is_mul_s) begin
         mul_a_r <= op1_s; mul_b_r <= val2_s; mul_rm_r <= op2_s; mul_br_r <= branch_s;
         mul_dest_r <= dest; mul_wb_r <= wb_en; mul_mr_r <= mem_r_en;
         mul_mw_r <= mem_w_en; mul_s_r <= s_bit;
      end
   end

   // EXE/MEM output register: load from ALU or multiply, drain on out_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0; out_alu_res <= '0; out_val_rm <= '0; out_branch_addr <= '0;
         out_dest <= '0; out_wb_en <= 1'b0; out_mem_r <= 1'b0; out_mem_w <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_alu_s) begin
         out_valid <= 1'b1; out_alu_res <= alu_res_s; out_val_rm <= op2_s;
         out_branch_addr <= branch_s; out_dest <= dest; out_wb_en <= wb_en;
         out_mem_r <= mem_r_en; out_mem_w <= mem_w_en;
      end else if (load_mul_s) begin
         out_valid <= 1'b1; out_alu_res <= mul_res_s; out_val_rm <= mul_rm_r;
         out_branch_addr <= mul_br_r; out_dest <= mul_dest_r; out_wb_en <= mul_wb_r;
         out_mem_r <= mul_mr_r; out_mem_w <= mul_mw_r;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // NZCV register: updated when a flag-setting result is loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= 4'b0000;
      end else if (load_alu_s & s_bit) begin
         status <= flags_s;
      end else if (load_mul_s & mul_s_r) begin
         status <= mul_flags_s;
      end
   end

endmodule
